register_file_mp: RTL and testbench



---
 rtl/register_file_mp_pkg.sv | 8 +
 rtl/register_file_mp_scoreboard.sv | 40 ++++
 rtl/register_file_mp.sv | 57 +++++
 tb/tb_register_file_mp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared constants and bus slicing helper for the register file
package register_file_mp_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_ZERO = 0;
  function automatic int lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/register_file_mp_scoreboard.sv
// reg_scoreboard: per-register busy bits with reserve/clear priority and read-port lookup
module reg_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_a
);
  logic [NREGS-1:0] busy, busy_nxt;
  // writes clear, a reserve sets and wins over a same-cycle write, x0 is never busy
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) if (we[j]) busy_nxt[wa[lo(j, AW) +: AW]] = 1'b0;
    if (rsv_en) busy_nxt[rsv_a] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end
  // busy vector register
  always_ff @(posedge clk) busy <= rst ? '0 : busy_nxt;
  for (genvar i = 0; i < NRD; i++) begin : g_rb
    logic [AW-1:0] a;
    logic hit;
    assign a = ra[lo(i, AW) +: AW];
    // a same-cycle write hides the busy bit, matching the data bypass
    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < NWR; j++) hit = hit | (we[j] && wa[lo(j, AW) +: AW] == a);
    end
    assign rbusy[i] = busy[a] & ~(hit & ~rst);
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with write bypass and busy scoreboard
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_a
);
  if (NREGS < 2 || NREGS != (1 << AW)) begin : g_bad_nregs
    $error("register_file_mp: NREGS must be a power of two >= 2");
  end
  logic [XLEN-1:0] regs [NREGS];
  // storage: later ports overwrite earlier ones so the highest index wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && wa[lo(j, AW) +: AW] != AW'(REG_ZERO)) regs[wa[lo(j, AW) +: AW]] <= wd[lo(j, XLEN) +: XLEN];
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] v;
    assign a = ra[lo(i, AW) +: AW];
    // bypass from the highest matching write port, disabled while in reset
    always_comb begin
      v = regs[a];
      for (int j = 0; j < NWR; j++)
        if (!rst && we[j] && wa[lo(j, AW) +: AW] == a) v = wd[lo(j, XLEN) +: XLEN];
    end
    assign rd[lo(i, XLEN) +: XLEN] = (a == AW'(REG_ZERO)) ? '0 : v;
  end
  reg_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk(clk),
    .rst(rst),
    .ra(ra),
    .rbusy(rbusy),
    .we(we),
    .wa(wa),
    .rsv_en(rsv_en),
    .rsv_a(rsv_a)
  );
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed and model-based checks of the multi-port register file
module tb_register_file_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;
  typedef struct {
    logic [XLEN-1:0] rd;
    logic busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NRD*AW-1:0] ra = '0;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0] rbusy;
  logic [NWR-1:0] we = '0;
  logic [NWR*AW-1:0] wa = '0;
  logic [NWR*XLEN-1:0] wd = '0;
  logic rsv_en = 1'b0;
  logic [AW-1:0] rsv_a = '0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [XLEN-1:0] mdl [NREGS];
  logic [NREGS-1:0] mbusy;

  register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk),
    .rst(rst),
    .ra(ra),
    .rd(rd),
    .rbusy(rbusy),
    .we(we),
    .wa(wa),
    .wd(wd),
    .rsv_en(rsv_en),
    .rsv_a(rsv_a)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, actual running expected done");
    $fatal(1, "timeout");
  end

  task automatic idle();
    we = '0;
    wa = '0;
    wd = '0;
    rsv_en = 1'b0;
    rsv_a = '0;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[j] = 1'b1;
    wa[j*AW +: AW] = a;
    wd[j*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    ra = {5'd31, 5'd5};
    set_wr(0, 5'd5, 32'hAAAA5555);
    rsv_en = 1'b1;
    rsv_a = 5'd5;
    @(posedge clk);
    #1;
    n_chk++; if (rd !== '0) begin n_fail++; $display("FAIL reset_rd: rd=%h expected 0", rd); end
    n_chk++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL reset_rbusy: rbusy=%b expected 00", rbusy); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    #2;
    n_chk++; if (rd[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_write_dropped: rd0=%h expected 0", rd[31:0]); end
    n_chk++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rsv_dropped: rbusy0=%b expected 0", rbusy[0]); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    ra = {5'd7, 5'd7};
    set_wr(0, 5'd7, 32'hDEADBEEF);
    #2;
    n_chk++; if (rd[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same: rd0=%h expected deadbeef", rd[31:0]); end
    n_chk++; if (rd[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_port1: rd1=%h expected deadbeef", rd[63:32]); end
    @(posedge clk);
    #1;
    idle();
    #1;
    n_chk++; if (rd[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_stored: rd0=%h expected deadbeef", rd[31:0]); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    ra = {5'd7, 5'd0};
    set_wr(0, 5'd0, 32'h12345678);
    rsv_en = 1'b1;
    rsv_a = 5'd0;
    #2;
    n_chk++; if (rd[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_same: rd0=%h expected 0", rd[31:0]); end
    @(posedge clk);
    #1;
    idle();
    #1;
    n_chk++; if (rd[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_after: rd0=%h expected 0", rd[31:0]); end
    n_chk++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL x0_rbusy: rbusy0=%b expected 0", rbusy[0]); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    ra = {5'd7, 5'd9};
    set_wr(0, 5'd9, 32'h1);
    set_wr(1, 5'd9, 32'h2);
    #2;
    n_chk++; if (rd[31:0] !== 32'h2) begin n_fail++; $display("FAIL collide_bypass: rd0=%h expected 2", rd[31:0]); end
    @(posedge clk);
    #1;
    idle();
    #1;
    n_chk++; if (rd[31:0] !== 32'h2) begin n_fail++; $display("FAIL collide_stored: rd0=%h expected 2", rd[31:0]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    ra = {5'd9, 5'd3};
    rsv_en = 1'b1;
    rsv_a = 5'd3;
    #2;
    n_chk++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_rsv_same: rbusy0=%b expected 0", rbusy[0]); end
    @(negedge clk);
    idle();
    #2;
    n_chk++; if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_rsv_next: rbusy0=%b expected 1", rbusy[0]); end
    @(negedge clk);
    set_wr(0, 5'd3, 32'h33);
    #2;
    n_chk++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_wr_same: rbusy0=%b expected 0", rbusy[0]); end
    n_chk++; if (rd[31:0] !== 32'h33) begin n_fail++; $display("FAIL sb_wr_data: rd0=%h expected 33", rd[31:0]); end
    @(negedge clk);
    idle();
    #2;
    n_chk++; if (rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_wr_after: rbusy0=%b expected 0", rbusy[0]); end
    @(negedge clk);
    set_wr(0, 5'd3, 32'h77);
    rsv_en = 1'b1;
    rsv_a = 5'd3;
    @(negedge clk);
    idle();
    #2;
    n_chk++; if (rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_rsv_wins: rbusy0=%b expected 1", rbusy[0]); end
    n_chk++; if (rd[31:0] !== 32'h77) begin n_fail++; $display("FAIL sb_rsv_wr_data: rd0=%h expected 77", rd[31:0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsv_en = 1'b1;
    rsv_a = 5'd4;
    @(negedge clk);
    idle();
    rst = 1'b1;
    ra = {5'd4, 5'd3};
    set_wr(0, 5'd4, 32'h44);
    #2;
    n_chk++; if (rbusy !== 2'b11) begin n_fail++; $display("FAIL rstmid_stored_busy: rbusy=%b expected 11", rbusy); end
    n_chk++; if (rd[63:32] !== 32'h0) begin n_fail++; $display("FAIL rstmid_no_bypass: rd1=%h expected 0", rd[63:32]); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    #2;
    n_chk++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL rstmid_busy_clear: rbusy=%b expected 00", rbusy); end
    n_chk++; if (rd !== '0) begin n_fail++; $display("FAIL rstmid_regs_clear: rd=%h expected 0", rd); end
  endtask

  task automatic test_random();
    exp_t e;
    for (int r = 0; r < NREGS; r++) mdl[r] = '0;
    mbusy = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      we = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wa[j*AW +: AW] = AW'($urandom_range(0, 7));
        wd[j*XLEN +: XLEN] = $urandom;
      end
      rsv_en = ($urandom_range(0, 3) == 0);
      rsv_a = AW'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) begin
        logic [AW-1:0] a;
        logic hit;
        a = ra[i*AW +: AW];
        e.rd = mdl[a];
        hit = 1'b0;
        for (int j = 0; j < NWR; j++)
          if (we[j] && wa[j*AW +: AW] == a) begin
            e.rd = wd[j*XLEN +: XLEN];
            hit = 1'b1;
          end
        if (a == '0) e.rd = '0;
        e.busy = (a != '0) && mbusy[a] && !hit;
        sb.push_back(e);
      end
      #2;
      for (int i = 0; i < NRD; i++) begin
        e = sb.pop_front();
        n_chk++;
        if (rd[i*XLEN +: XLEN] !== e.rd || rbusy[i] !== e.busy) begin
          n_fail++;
          $display("FAIL random_c%0d_p%0d: rd=%h rbusy=%b expected rd=%h rbusy=%b", c, i, rd[i*XLEN +: XLEN], rbusy[i], e.rd, e.busy);
        end
      end
      @(posedge clk);
      for (int j = 0; j < NWR; j++)
        if (we[j]) begin
          if (wa[j*AW +: AW] != '0) mdl[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
          mbusy[wa[j*AW +: AW]] = 1'b0;
        end
      if (rsv_en) mbusy[rsv_a] = 1'b1;
      mbusy[0] = 1'b0;
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_collision();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
